sig_pair_feeder: RTL and testbench
==================================

# sig_pair_feeder

Transmit-side front end for the sigma/covariance datapath. It accepts two independent valid/ready beat streams carrying the X and Y images and merges them into lock-step beat pairs. It drives the stall-gated `in_x`/`in_y`/`stall`/`aresetn` interface that the Gaussian-window statistic blocks consume. Per frame it sequences a pipeline reset, streams the frame, and injects zero flush beats so the windowed outputs of the last rows drain.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per beat.
- `IMAGE_DIM`, 512, image width and height in pixels (square frame).
- `DATA_WIDTH`, 8*PIXELS_PER_BEAT, beat width in bits.
- `RST_CYCLES`, 2, length of the downstream reset pulse in cycles (minimum 1).
- `FLUSH_ROWS`, 5, zero rows injected after each frame (half Gaussian window).
- `clk`  in  1  single clock; all logic on posedge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `x_tdata`  in  DATA_WIDTH  X pixel beat; pixel j at bits [8j+7:8j].
- `x_tvalid`  in  1  X beat valid.
- `x_tlast`  in  1  X last beat of frame.
- `x_tready`  out  1  X beat accepted.
- `y_tdata`, `y_tvalid`, `y_tlast`, `y_tready`  same as X, for Y.
- `hold`  in  1  downstream backpressure; forces a stall cycle.
- `out_x`, `out_y`  out  DATA_WIDTH  beat pair to the statistic pipeline.
- `out_stall`  out  1  high means the pipeline must not advance.
- `out_aresetn`  out  1  active-low reset to the pipeline, honoured only on non-stalled cycles.
- `out_valid`  out  1  the advancing beat is image data, not flush.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse after flush completes.
- `framing_err`  out  1  sticky; tlast was misplaced.

## Operation
- Derived constants:
  - BEATS_PER_ROW = IMAGE_DIM/PIXELS_PER_BEAT.
  - FRAME_BEATS = IMAGE_DIM*BEATS_PER_ROW.
  - FLUSH_BEATS = FLUSH_ROWS*BEATS_PER_ROW.
- States and transitions:
  - IDLE → RST when `x_tvalid && y_tvalid`.
  - RST → STREAM after RST_CYCLES cycles.
  - STREAM → FLUSH on the accepted beat FRAME_BEATS-1.
  - FLUSH → DONE on flush beat FLUSH_BEATS-1.
  - DONE → IDLE after one cycle.
- RST: `out_aresetn`=0, `out_stall`=0, data 0, `out_valid`=0. `hold` is ignored here.
- STREAM:
  - fire = `x_tvalid && y_tvalid && !hold`.
  - `x_tready` = `y_tready` = fire (combinational), so both streams are always consumed together.
  - A lone valid on one side is never accepted.
- Beat counters: `col` in 0..BEATS_PER_ROW-1 and `row` in 0..IMAGE_DIM-1, both advancing on fire. `col` wraps to 0 and increments `row`.
- tlast check on each fire:
  - Expected value: `x_tlast` = `y_tlast` = (beat is FRAME_BEATS-1).
  - Any mismatch sets `framing_err`. It clears only on `aresetn`.
  - Frame length is counter-defined; tlast never ends a frame early.
- FLUSH: when `!hold`, emit a zero beat with `out_stall`=0 and `out_valid`=0. A separate counter counts these beats. tready stays 0.
- DONE: `frame_done`=1 for one cycle.
- `aresetn` low at any time: all state returns to IDLE, counters clear, and outputs take their reset values. A partial frame is discarded.

## Timing
- Reset values of all outputs:
  - `out_x`=`out_y`=0
  - `out_stall`=1
  - `out_aresetn`=0
  - `out_valid`=0
  - `busy`=0
  - `frame_done`=0
  - `framing_err`=0
  - tready=0
- `out_*` are registered with 1-cycle latency: a fire in cycle n gives `out_stall`=0 and data in cycle n+1. A non-fire cycle gives `out_stall`=1 in n+1, with data held.
- `out_aresetn` returns to 1 on the cycle of the first STREAM output, so the first image beat sees reset deasserted.
- `hold` in cycle n gives `out_stall`=1 in n+1, in any state except RST.
- `busy` is registered from state.
- `frame_done` is asserted the cycle after the last flush beat is presented.
- With continuous valid and no `hold`, a frame takes 1 + RST_CYCLES + FRAME_BEATS + FLUSH_BEATS + 1 cycles from first valid to `frame_done`.
- A new frame's valid may arrive during DONE; it is accepted only after IDLE → RST.

## Structure
- Shared package `sig_pkg`: state enum (IDLE, RST, STREAM, FLUSH, DONE) and the derived-constant functions BEATS_PER_ROW, FRAME_BEATS and FLUSH_BEATS. The statistic blocks reuse these.
- One sub-module, `beat_pos_counter`: col/row counter with wrap, enable, clear and a last-beat flag. It is instantiated for STREAM position; FLUSH uses a plain counter.

## Test plan
Bench parameters: PIXELS_PER_BEAT=16, IMAGE_DIM=32, which gives BEATS_PER_ROW=2, FRAME_BEATS=64 and FLUSH_BEATS=10.
- Continuous frame, both valid every cycle, beat k = k replicated per byte:
  - Expect 2 reset cycles, then 64 `out_valid` beats with `out_x`=`out_y`=k in order, then 10 zero beats, then `frame_done` at cycle 78.
- Skewed streams: Y valid lags X by 3 cycles on every beat.
  - Expect no beat accepted until both are valid, `out_stall`=1 in the gap cycles, and pairs never misaligned.
- `hold` asserted for 5 cycles at beat 20 and again during flush beat 4.
  - Expect tready=0 and `out_stall`=1 for exactly those 5 cycles plus 1 latency, no lost or duplicated beats, and a flush total of still 10.
- tlast asserted on beat 40.
  - Expect `framing_err`=1 from then on, the frame still running 64 beats, and `framing_err` cleared only by `aresetn`.
- `aresetn` low for 1 cycle at beat 30.
  - Expect all outputs at reset values the next cycle, state IDLE, and the following frame starting with a fresh RST sequence and beat 0 counted from 0.

Source files
------------

// File: rtl/sig_pkg.sv
// Shared definitions for the sigma/covariance front end and statistic blocks.
// Provides the sequencer state enum and the frame-geometry helper functions.
package sig_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Beats making up one image row.
    function automatic int unsigned beats_per_row(input int unsigned pixels_per_beat,
                                                  input int unsigned image_dim);
        return image_dim / pixels_per_beat;
    endfunction

    // Beats making up one square frame.
    function automatic int unsigned frame_beats(input int unsigned pixels_per_beat,
                                                input int unsigned image_dim);
        return image_dim * beats_per_row(pixels_per_beat, image_dim);
    endfunction

    // Zero beats injected after a frame to drain the window.
    function automatic int unsigned flush_beats(input int unsigned flush_rows,
                                                input int unsigned pixels_per_beat,
                                                input int unsigned image_dim);
        return flush_rows * beats_per_row(pixels_per_beat, image_dim);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beat_pos_counter.sv
// Column/row beat position counter for one frame.
// Ports:
//   clk, aresetn : clock and synchronous active-low reset
//   clear        : synchronous return to position (0,0)
//   enable       : advance one beat (col wraps into row)
//   last         : current position is the final beat of the frame
module beat_pos_counter
    import sig_pkg::*;
#(
    parameter int unsigned COLS = 2,
    parameter int unsigned ROWS = 32
) (
    input  logic clk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CW = cnt_width(COLS);
    localparam int unsigned RW = cnt_width(ROWS);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;

    assign col_end = (col == CW'(COLS - 1));
    assign row_end = (row == RW'(ROWS - 1));
    assign last    = col_end && row_end;

    // Position advance; the row wraps too so the counter is ready for the next frame.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sig_pair_feeder.sv
// Merges the X and Y beat streams into lock-step pairs for the statistic
// pipeline, framing each image with a pipeline reset and trailing zero rows.
// Ports:
//   clk, aresetn                    : clock, synchronous active-low reset
//   x_t*/y_t*                       : valid/ready beat streams (X and Y images)
//   hold                            : downstream backpressure
//   out_x, out_y                    : beat pair to the pipeline
//   out_stall, out_aresetn          : pipeline advance gate and reset
//   out_valid                       : advancing beat carries image data
//   busy, frame_done, framing_err   : status
module sig_pair_feeder
    import sig_pkg::*;
#(
    parameter int unsigned PIXELS_PER_BEAT = 16,
    parameter int unsigned IMAGE_DIM       = 512,
    parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int unsigned RST_CYCLES      = 2,
    parameter int unsigned FLUSH_ROWS      = 5
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] x_tdata,
    input  logic                  x_tvalid,
    input  logic                  x_tlast,
    output logic                  x_tready,
    input  logic [DATA_WIDTH-1:0] y_tdata,
    input  logic                  y_tvalid,
    input  logic                  y_tlast,
    output logic                  y_tready,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_stall,
    output logic                  out_aresetn,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  framing_err
);

    localparam int unsigned BEATS_PER_ROW = beats_per_row(PIXELS_PER_BEAT, IMAGE_DIM);
    localparam int unsigned FLUSH_BEATS   = flush_beats(FLUSH_ROWS, PIXELS_PER_BEAT, IMAGE_DIM);
    localparam int unsigned RCW           = cnt_width(RST_CYCLES);
    localparam int unsigned FCW           = cnt_width(FLUSH_BEATS);

    state_t          state;
    state_t          state_nxt;
    logic [RCW-1:0]  rst_cnt;
    logic [FCW-1:0]  flush_cnt;
    logic            pos_last;
    logic            fire;
    logic            flush_fire;
    logic            rst_done;
    logic            flush_last;

    logic [DATA_WIDTH-1:0] out_x_d;
    logic [DATA_WIDTH-1:0] out_y_d;
    logic                  out_stall_d;
    logic                  out_aresetn_d;
    logic                  out_valid_d;
    logic                  frame_done_d;
    logic                  framing_err_d;

    // A pair is consumed only when both sides offer a beat; gated by reset so
    // a beat presented in a reset cycle is never lost.
    assign fire       = aresetn && (state == STREAM) && x_tvalid && y_tvalid && !hold;
    assign flush_fire = (state == FLUSH) && !hold;
    assign x_tready   = fire;
    assign y_tready   = fire;
    assign rst_done   = (rst_cnt == RCW'(RST_CYCLES - 1));
    assign flush_last = (flush_cnt == FCW'(FLUSH_BEATS - 1));

    // Image beat position within the frame.
    beat_pos_counter #(
        .COLS (BEATS_PER_ROW),
        .ROWS (IMAGE_DIM)
    ) u_pos (
        .clk     (clk),
        .aresetn (aresetn),
        .clear   (state == RST),
        .enable  (fire),
        .last    (pos_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (x_tvalid && y_tvalid) state_nxt = RST;
            RST:     if (rst_done) state_nxt = STREAM;
            STREAM:  if (fire && pos_last) state_nxt = FLUSH;
            FLUSH:   if (flush_fire && flush_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset-pulse and flush-beat counters.
    always_ff @(posedge clk) begin
        if (!aresetn || (state != RST)) begin
            rst_cnt <= '0;
        end else begin
            rst_cnt <= rst_cnt + RCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn || (state == RST)) begin
            flush_cnt <= '0;
        end else if (flush_fire) begin
            flush_cnt <= flush_cnt + FCW'(1);
        end
    end

    // Output next values; any non-advancing cycle stalls and holds data.
    always_comb begin
        out_x_d       = out_x;
        out_y_d       = out_y;
        out_stall_d   = 1'b1;
        out_aresetn_d = out_aresetn;
        out_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        framing_err_d = framing_err;
        unique case (state)
            RST: begin
                out_stall_d   = 1'b0;
                out_aresetn_d = 1'b0;
                out_x_d       = '0;
                out_y_d       = '0;
            end
            STREAM: begin
                if (fire) begin
                    out_stall_d   = 1'b0;
                    out_aresetn_d = 1'b1;
                    out_valid_d   = 1'b1;
                    out_x_d       = x_tdata;
                    out_y_d       = y_tdata;
                    // tlast must mark exactly the counter-defined final beat.
                    if ((x_tlast != pos_last) || (y_tlast != pos_last)) begin
                        framing_err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_fire) begin
                    out_stall_d = 1'b0;
                    out_x_d     = '0;
                    out_y_d     = '0;
                end
            end
            DONE:    frame_done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_x       <= '0;
            out_y       <= '0;
            out_stall   <= 1'b1;
            out_aresetn <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            out_x       <= out_x_d;
            out_y       <= out_y_d;
            out_stall   <= out_stall_d;
            out_aresetn <= out_aresetn_d;
            out_valid   <= out_valid_d;
            busy        <= (state != IDLE);
            frame_done  <= frame_done_d;
            framing_err <= framing_err_d;
        end
    end

endmodule

// File: tb/tb_sig_pair_feeder.sv
// Bench for sig_pair_feeder: scenario table with hand-derived frame timing,
// a reset-abort sequence, randomized frames, and a per-cycle monitor that
// checks handshakes, latency, ordering and frame composition.
module tb_sig_pair_feeder;

    localparam int unsigned PPB    = 16;
    localparam int unsigned DIM    = 32;
    localparam int unsigned DW     = 8 * PPB;
    localparam int unsigned NBEAT  = 64;
    localparam int unsigned NFLUSH = 10;
    localparam int unsigned NRST   = 2;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] x_tdata, y_tdata;
    logic          x_tvalid, y_tvalid, x_tlast, y_tlast;
    logic          x_tready, y_tready;
    logic          hold;
    logic [DW-1:0] out_x, out_y;
    logic          out_stall, out_aresetn, out_valid, busy, frame_done, framing_err;

    sig_pair_feeder #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .DATA_WIDTH      (DW),
        .RST_CYCLES      (NRST),
        .FLUSH_ROWS      (5)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .x_tdata     (x_tdata),
        .x_tvalid    (x_tvalid),
        .x_tlast     (x_tlast),
        .x_tready    (x_tready),
        .y_tdata     (y_tdata),
        .y_tvalid    (y_tvalid),
        .y_tlast     (y_tlast),
        .y_tready    (y_tready),
        .hold        (hold),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_stall   (out_stall),
        .out_aresetn (out_aresetn),
        .out_valid   (out_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .framing_err (framing_err)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         base   = 0;
    logic [7:0] y_xor  = 8'h00;
    bit         mon_en = 1'b0;

    function automatic logic [DW-1:0] pat(input int v, input logic [7:0] msk);
        logic [7:0] b;
        b = 8'(v) ^ msk;
        return {PPB{b}};
    endfunction

    task automatic chk_d(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Monitor: previous-cycle stimulus plus a frame-level model of the streams.
    bit            p_fire = 1'b0, p_hold = 1'b0, p_rst = 1'b0;
    logic [DW-1:0] p_xd = '0, p_yd = '0;
    int            ob = 0, nf = 0, nr = 0, mb = 0;
    bit            exp_err = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk_i("tready_pair", int'(y_tready), int'(x_tready));
            if (x_tready)
                chk_i("tready_cond", int'({x_tvalid, y_tvalid, hold, aresetn}), int'(4'b1101));
            chk_i("out_valid_latency", int'(out_valid), int'(p_fire));
            if (p_fire) begin
                chk_i("fire_stall_rst", int'({out_stall, out_aresetn}), 1);
                chk_d("fire_x", out_x, p_xd);
                chk_d("fire_y", out_y, p_yd);
            end
            if (p_hold && out_aresetn) chk_i("hold_stall", int'(out_stall), 1);
            if (p_rst) begin
                chk_i("reset_outs", int'({out_stall, out_aresetn, out_valid, busy, frame_done, framing_err}),
                      int'(6'b10_0000));
                chk_d("reset_data", out_x | out_y, '0);
            end
            chk_i("framing_err", int'(framing_err), int'(exp_err));
            if (!out_stall && out_valid) begin
                chk_d("order_x", out_x, pat(base + ob, 8'h00));
                chk_d("order_y", out_y, pat(base + ob, y_xor));
                ob++;
            end
            if (!out_stall && !out_valid) begin
                chk_d("zero_beat", out_x | out_y, '0);
                if (out_aresetn) nf++;
                else nr++;
            end
            if (frame_done) begin
                chk_i("frame_beats", ob, int'(NBEAT));
                chk_i("frame_flush", nf, int'(NFLUSH));
                chk_i("frame_rst", nr, int'(NRST));
                ob = 0; nf = 0; nr = 0;
            end
            if (!aresetn) begin
                exp_err = 1'b0; mb = 0; ob = 0; nf = 0; nr = 0;
            end else if (x_tready) begin
                if ((x_tlast != (mb == int'(NBEAT) - 1)) || (y_tlast != (mb == int'(NBEAT) - 1)))
                    exp_err = 1'b1;
                mb = (mb == int'(NBEAT) - 1) ? 0 : mb + 1;
            end
            p_fire = x_tready;
            p_xd   = x_tdata;
            p_yd   = y_tdata;
            p_hold = hold;
            p_rst  = !aresetn;
        end
    end

    // Offers one frame of beats. Cycle 0 is the first cycle X is offered.
    // done_cyc: cycle of frame_done, -2 if aborted by reset, -1 on timeout.
    task automatic run_frame(input int y_lag, input int hold_beat, input int fhold_len,
                             input int bad_tlast, input int rst_beat, input bit rnd,
                             output int done_cyc);
        int k, age, xl, yl, hold_left, since_last, t;
        bit hold_used, fin;
        k = 0; age = 0; hold_left = 0; since_last = -1; t = 0;
        hold_used = 1'b0; fin = 1'b0; done_cyc = -1;
        xl = rnd ? int'($urandom_range(0, 2)) : 0;
        yl = rnd ? int'($urandom_range(0, 3)) : y_lag;
        while (!fin && t < 4000) begin
            if (since_last >= 0) since_last++;
            if (!hold_used && k == hold_beat && age == 0) begin
                hold_left = 5;
                hold_used = 1'b1;
            end
            if (since_last == 5 && fhold_len > 0) hold_left = fhold_len;
            x_tvalid = (k < int'(NBEAT)) && (age >= xl);
            y_tvalid = (k < int'(NBEAT)) && (age >= yl);
            x_tdata  = pat(base + k, 8'h00);
            y_tdata  = pat(base + k, y_xor);
            x_tlast  = (k == int'(NBEAT) - 1) || (k == bad_tlast);
            y_tlast  = x_tlast;
            hold     = (hold_left > 0) || (rnd && $urandom_range(0, 5) == 0);
            aresetn  = !(k == rst_beat && age == 0);
            @(negedge clk);
            if (!aresetn) begin
                fin = 1'b1;
                done_cyc = -2;
            end else begin
                if (x_tready) begin
                    k++;
                    age = 0;
                    xl = rnd ? int'($urandom_range(0, 2)) : 0;
                    yl = rnd ? int'($urandom_range(0, 3)) : y_lag;
                    if (k == int'(NBEAT)) since_last = 0;
                end else begin
                    age++;
                end
                if (hold_left > 0) hold_left--;
                if (frame_done) begin
                    fin = 1'b1;
                    done_cyc = t;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        x_tvalid = 1'b0; y_tvalid = 1'b0; x_tlast = 1'b0; y_tlast = 1'b0;
        hold = 1'b0; aresetn = 1'b1;
        if (!fin) chk_i("frame_timeout", 0, 1);
        if (done_cyc >= 0) begin
            @(negedge clk);
            chk_i("done_pulse_busy", int'({busy, frame_done}), 0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int         y_lag;
        int         hold_beat;
        int         fhold;
        int         bad_tlast;
        logic [7:0] yx;
        int         exp_done;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int   d;
        aresetn = 1'b0; hold = 1'b0;
        x_tvalid = 1'b0; y_tvalid = 1'b0; x_tlast = 1'b0; y_tlast = 1'b0;
        x_tdata = '0; y_tdata = '0;

        // Continuous; hold at beat 20 and flush beat 4; stray tlast; Y lagging 3.
        vecs[0] = '{y_lag: 0, hold_beat: -1, fhold: 0, bad_tlast: -1, yx: 8'h00, exp_done: 78,  exp_err: 1'b0};
        vecs[1] = '{y_lag: 0, hold_beat: 20, fhold: 5, bad_tlast: -1, yx: 8'h5A, exp_done: 88,  exp_err: 1'b0};
        vecs[2] = '{y_lag: 0, hold_beat: -1, fhold: 0, bad_tlast: 40, yx: 8'h33, exp_done: 78,  exp_err: 1'b1};
        vecs[3] = '{y_lag: 3, hold_beat: -1, fhold: 0, bad_tlast: -1, yx: 8'hC3, exp_done: 270, exp_err: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("reset_state", int'({out_stall, out_aresetn, out_valid, busy, frame_done, framing_err, x_tready, y_tready}),
              int'(8'b1000_0000));
        chk_d("reset_out_x", out_x, '0);
        chk_d("reset_out_y", out_y, '0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            base  = 16 * i;
            y_xor = vecs[i].yx;
            run_frame(vecs[i].y_lag, vecs[i].hold_beat, vecs[i].fhold, vecs[i].bad_tlast, -1, 1'b0, d);
            chk_i("done_cycle", d, vecs[i].exp_done);
            chk_i("sticky_err", int'(framing_err), int'(vecs[i].exp_err));
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset pulse while beat 30 is offered, then a fresh frame from beat 0.
        base  = 100;
        y_xor = 8'h0F;
        run_frame(0, -1, 0, -1, 30, 1'b0, d);
        chk_i("abort_seen", d, -2);
        @(negedge clk);
        chk_i("abort_outs", int'({out_stall, out_aresetn, out_valid, busy, frame_done, framing_err, x_tready}),
              int'(7'b100_0000));
        chk_d("abort_data", out_x | out_y, '0);
        @(posedge clk); #1;
        base  = 0;
        y_xor = 8'h00;
        run_frame(0, -1, 0, -1, -1, 1'b0, d);
        chk_i("restart_done_cycle", d, 78);
        chk_i("restart_err", int'(framing_err), 0);

        // Randomized skew and backpressure.
        for (int i = 0; i < 3; i++) begin
            base  = 20 * i + 7;
            y_xor = 8'(8'h11 * (i + 1));
            run_frame(0, -1, 0, -1, -1, 1'b1, d);
            chk_i("rnd_frame_done", int'(d > 0), 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        chk_i("rnd_err", int'(framing_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
